// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes on both
// sides. Retires RADIX_BITS multiplier bits per cycle on operand magnitudes
// and applies the result sign once, on the final iteration.
module seq_multiplier #(
  parameter int WIDTH      = 64,
  parameter int RADIX_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + RADIX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mcand;    // |a|
  logic [WIDTH-1:0] mplier;   // |b|, shifted right each RUN cycle
  logic             neg;      // result sign
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [MW-1:0]    pp;
  logic [PW-1:0]    pp_shift;
  logic [PW-1:0]    acc_next;

  // Handshake and operand conditioning; in_ready never depends on in_valid.
  assign in_ready = reset & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign last     = (state == RUN) && (count == CW'(N - 1));
  assign sa       = a_signed & a[WIDTH-1];
  assign sb       = b_signed & b[WIDTH-1];
  assign a_mag    = sa ? -a : a;
  assign b_mag    = sb ? -b : b;

  // Partial product of |a| with the low multiplier digit, aligned to the
  // digit's weight and added to the running accumulator.
  always_comb begin
    pp       = {{RADIX_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, mplier[RADIX_BITS-1:0]};
    pp_shift = PW'(pp) << (int'(count) * RADIX_BITS);
    acc_next = acc + pp_shift;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register uses <= so all flops sample pre-edge values;
    // blocking = here would make later reads see this cycle's update.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand registers are always loaded on accept before use, so they carry
  // no reset.
  always_ff @(posedge clk) begin
    // NOTE: leaving pure datapath registers out of reset keeps the reset net
    // small; their contents are never observed before the first accept.
    if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= sa ^ sb;
    end else if (state == RUN) begin
      mplier <= mplier >> RADIX_BITS;
    end
  end

  // Accumulator, iteration counter and result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      count     <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      if (accept) begin
        acc   <= '0;
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (last) p <= neg ? -acc_next : acc_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a default 64x64 radix-2 instance and a
// 16x16 radix-16 instance. Stimulus pushes hand-computed products with the
// accept cycle; per-instance monitors pop and compare on each output handshake.
module tb_seq_multiplier;

  localparam int N1 = 64;
  localparam int N2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
  logic [63:0]  a, b;
  logic [127:0] p;

  logic         in_valid2, in_ready2, a_signed2, b_signed2, out_valid2, out_ready2;
  logic [15:0]  a2, b2;
  logic [31:0]  p2;

  seq_multiplier dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  seq_multiplier #(.WIDTH(16), .RADIX_BITS(4)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .a_signed(a_signed2), .b_signed(b_signed2),
    .out_valid(out_valid2), .out_ready(out_ready2), .p(p2)
  );

  typedef struct {
    logic [127:0] p;
    int           k;   // cycle index of the accept edge
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor for the 64-bit instance.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset) seen = 1'b0;
      else if (out_valid) begin
        if (q1.size() == 0) fail("unexpected_out_valid_64");
        else begin
          if (!seen) begin
            check("latency_64", 128'(cyc - q1[0].k), 128'(N1));
            seen = 1'b1;
          end
          if (out_ready) begin
            check("p_64", p, q1[0].p);
            void'(q1.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Monitor for the 16-bit instance.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset) seen = 1'b0;
      else if (out_valid2) begin
        if (q2.size() == 0) fail("unexpected_out_valid_16");
        else begin
          if (!seen) begin
            check("latency_16", 128'(cyc - q2[0].k), 128'(N2));
            seen = 1'b1;
          end
          if (out_ready2) begin
            check("p_16", 128'(p2), q2[0].p);
            void'(q2.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present operands on the 64-bit instance until accepted; operands are
  // scrambled right after the accept edge to show they are ignored in RUN.
  task automatic issue1(input logic [63:0] av, input logic [63:0] bv,
                        input logic as_i, input logic bs_i,
                        input logic [127:0] ep, input logic ordy);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; a_signed = as_i; b_signed = bs_i;
    out_ready = ordy;
    #1;
    while (!in_ready && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) begin
      fail("accept_timeout_64");
      in_valid = 1'b0;
      return;
    end
    q1.push_back('{p: ep, k: cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av ^ 64'h5A5A_0F0F_3C3C_9999;
    b = bv + 64'd12345;
    a_signed = ~as_i;
    b_signed = ~bs_i;
  endtask

  task automatic issue2(input logic [15:0] av, input logic [15:0] bv,
                        input logic as_i, input logic bs_i, input logic [31:0] ep);
    int t = 0;
    @(negedge clk);
    in_valid2 = 1'b1; a2 = av; b2 = bv; a_signed2 = as_i; b_signed2 = bs_i;
    #1;
    while (!in_ready2 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready2) begin
      fail("accept_timeout_16");
      in_valid2 = 1'b0;
      return;
    end
    q2.push_back('{p: 128'(ep), k: cyc + 1});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    a2 = ~av;
    b2 = bv ^ 16'h1234;
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < limit) begin
      @(negedge clk); t++;
    end
    @(negedge clk); #2;
  endtask

  initial begin
    int t;
    int stray;
    reset = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; a_signed2 = 1'b0; b_signed2 = 1'b0; out_ready2 = 1'b1;

    // Reset held for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("in_ready_in_reset", 128'(in_ready), 128'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_after_release", 128'(in_ready), 128'(1));
    check("out_valid_after_reset", 128'(out_valid), 128'(0));
    check("p_after_reset", p, 128'(0));
    check("p2_after_reset", 128'(p2), 128'(0));

    // Unsigned max, then back-to-back signed corners using the same-edge accept.
    issue1(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);
    issue1(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    issue1(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 1'b1);
    // Mixed modes.
    issue1(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1);
    issue1(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0,
           128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b1);
    issue1(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB, 1'b1);
    drain(400);

    // Backpressure: result held with out_ready low.
    issue1(64'd5, 64'd7, 1'b0, 1'b0, 128'd35, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (!out_valid) fail("out_valid_timeout_backpressure");
    for (int i = 0; i < 10; i++) begin
      check("p_held", p, 128'd35);
      check("in_ready_held_low", 128'(in_ready), 128'(0));
      @(negedge clk); #1;
    end
    // Release with a new operand pair on the same edge.
    issue1(64'd7, 64'd6, 1'b0, 1'b0, 128'd42, 1'b1);
    drain(200);

    // Abort mid-RUN at count == 30.
    issue1(64'h1234_5678, 64'h10, 1'b0, 1'b0, 128'h1_2345_6780, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    void'(q1.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_after_abort", 128'(in_ready), 128'(1));
    stray = 0;
    for (int i = 0; i < N1 + 10; i++) begin
      @(negedge clk); #1;
      if (out_valid) stray++;
    end
    check("no_out_valid_after_abort", 128'(stray), 128'(0));
    issue1(64'd3, 64'd4, 1'b0, 1'b0, 128'd12, 1'b1);
    drain(200);

    // Corner vectors on the 16-bit radix-16 instance.
    issue2(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001);
    issue2(16'h8000, 16'h8000, 1'b1, 1'b1, 32'h4000_0000);
    issue2(16'hFFFD, 16'h0005, 1'b1, 1'b1, 32'hFFFF_FFF1);
    issue2(16'hFFFF, 16'h0002, 1'b1, 1'b0, 32'hFFFF_FFFE);
    issue2(16'hFFFF, 16'h0002, 1'b0, 1'b0, 32'h0001_FFFE);
    drain(100);

    check("scoreboard_drained", 128'(q1.size() + q2.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
